// File: rtl/switch_pkg.sv
// Shared constants and types for the buffered, context-switched DySER fabric switch.
package switch_pkg;

  localparam int N_IN  = 5;
  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  localparam int CTX_WORD_W = 24;
  localparam logic [CTX_WORD_W-1:0] CTX_RESET = 24'o77777777;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;

  // input directions double as select values
  localparam int IN_N  = 0;
  localparam int IN_E  = 1;
  localparam int IN_W  = 2;
  localparam int IN_S  = 3;
  localparam int IN_NW = 4;

  // output index k owns select field [3k+2:3k] of the context word
  localparam int OUT_N  = 0;
  localparam int OUT_E  = 1;
  localparam int OUT_W  = 2;
  localparam int OUT_S  = 3;
  localparam int OUT_NW = 4;
  localparam int OUT_NE = 5;
  localparam int OUT_SW = 6;
  localparam int OUT_SE = 7;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } ctx_state_t;

  function automatic int sel_ofs(input int out_idx);
    return out_idx * SEL_W;
  endfunction

  function automatic logic [SEL_W-1:0] sel_field(input logic [CTX_WORD_W-1:0] word,
                                                 input int out_idx);
    return word[sel_ofs(out_idx) +: SEL_W];
  endfunction

endpackage

// File: rtl/switch_in_fifo.sv
// Per-input token FIFO; a push into a full FIFO is accepted only alongside a pop.
module switch_in_fifo #(
  parameter int DATA_W    = 64,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_pop, do_push;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/switch_ctx_buf.sv
// Buffered 5-in/8-out DySER switch with N_CTX routing contexts, credits and multicast.
// Optional stall_cnt output when SWITCH_STALL_CNT_EN is defined.
//   state | meaning
//   RUN   | routing under ctx_active, watching ctx_sel
//   DRAIN | routing under old context until FIFOs and outputs are empty
//   SWAP  | one cycle, no dequeue, ctx_active <= ctx_sel
module switch_ctx_buf
  import switch_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int N_CTX     = 2,
  parameter int BUF_DEPTH = 2,
  localparam int CTX_W    = (N_CTX > 1) ? $clog2(N_CTX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   d_in_NW,
  input  logic [DATA_W:0]   d_in_N,
  input  logic [DATA_W:0]   d_in_E,
  input  logic [DATA_W:0]   d_in_W,
  input  logic [DATA_W:0]   d_in_S,
  output logic              c_out_NW,
  output logic              c_out_N,
  output logic              c_out_E,
  output logic              c_out_W,
  output logic              c_out_S,
  output logic [DATA_W:0]   d_out_NW,
  output logic [DATA_W:0]   d_out_N,
  output logic [DATA_W:0]   d_out_NE,
  output logic [DATA_W:0]   d_out_E,
  output logic [DATA_W:0]   d_out_SE,
  output logic [DATA_W:0]   d_out_S,
  output logic [DATA_W:0]   d_out_SW,
  output logic [DATA_W:0]   d_out_W,
  input  logic              c_in_NW,
  input  logic              c_in_N,
  input  logic              c_in_NE,
  input  logic              c_in_E,
  input  logic              c_in_SE,
  input  logic              c_in_S,
  input  logic              c_in_SW,
  input  logic              c_in_W,
  input  logic              conf_en,
  input  logic [CTX_W-1:0]  conf_ctx,
  input  logic [CTX_W-1:0]  ctx_sel,
  output logic [CTX_W-1:0]  ctx_active,
  output logic              ctx_busy,
`ifdef SWITCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              err
);

  localparam int CRD_W     = $clog2(BUF_DEPTH + 1);
  localparam int CTX_SLOTS = 2 ** CTX_W;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);
  localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

  logic [DATA_W:0]       d_in    [N_IN];
  logic [DATA_W-1:0]     head    [N_IN];
  logic [N_IN-1:0]       push, pop, empty, full, overflow, blocked;
  logic [N_IN-1:0]       c_out_q;
  logic [N_OUT-1:0]      c_in, fire, crd_ovf, out_valid;
  logic [DATA_W-1:0]     route   [N_OUT];
  logic [DATA_W:0]       d_out_q [N_OUT];
  logic [CRD_W-1:0]      credit  [N_OUT];
  logic [SEL_W-1:0]      sel     [N_OUT];
  logic [CTX_WORD_W-1:0] ctx_mem [CTX_SLOTS];
  logic [CTX_WORD_W-1:0] ctx_word;
  logic                  conf_ok;
  ctx_state_t            state;

  assign d_in[IN_N]  = d_in_N;
  assign d_in[IN_E]  = d_in_E;
  assign d_in[IN_W]  = d_in_W;
  assign d_in[IN_S]  = d_in_S;
  assign d_in[IN_NW] = d_in_NW;

  assign c_in[OUT_N]  = c_in_N;
  assign c_in[OUT_E]  = c_in_E;
  assign c_in[OUT_W]  = c_in_W;
  assign c_in[OUT_S]  = c_in_S;
  assign c_in[OUT_NW] = c_in_NW;
  assign c_in[OUT_NE] = c_in_NE;
  assign c_in[OUT_SW] = c_in_SW;
  assign c_in[OUT_SE] = c_in_SE;

  assign d_out_N  = d_out_q[OUT_N];
  assign d_out_E  = d_out_q[OUT_E];
  assign d_out_W  = d_out_q[OUT_W];
  assign d_out_S  = d_out_q[OUT_S];
  assign d_out_NW = d_out_q[OUT_NW];
  assign d_out_NE = d_out_q[OUT_NE];
  assign d_out_SW = d_out_q[OUT_SW];
  assign d_out_SE = d_out_q[OUT_SE];

  assign c_out_N  = c_out_q[IN_N];
  assign c_out_E  = c_out_q[IN_E];
  assign c_out_W  = c_out_q[IN_W];
  assign c_out_S  = c_out_q[IN_S];
  assign c_out_NW = c_out_q[IN_NW];

  // Context store: slots beyond N_CTX stay at reset and are never written.
  assign conf_ok  = (32'(conf_ctx) < N_CTX);
  assign ctx_word = ctx_mem[ctx_active];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CTX_SLOTS; k++) ctx_mem[k] <= CTX_RESET;
    end else if (conf_en && conf_ok) begin
      ctx_mem[conf_ctx] <= d_in_N[CTX_WORD_W:1];
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_sel
    logic [SEL_W-1:0] field;
    assign field        = sel_field(ctx_word, o);
    assign sel[o]       = (field < SEL_W'(N_IN)) ? field : SEL_NONE;
    assign out_valid[o] = d_out_q[o][0];
  end

  // The config word rides on d_in_N, so it must not also become a token.
  always_comb begin
    for (int i = 0; i < N_IN; i++) push[i] = d_in[i][0];
    if (conf_en) push[IN_N] = 1'b0;
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_fifo
    switch_in_fifo #(
      .DATA_W   (DATA_W),
      .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (d_in[i][DATA_W:1]),
      .head    (head[i]),
      .empty   (empty[i]),
      .full    (full[i]),
      .overflow(overflow[i])
    );
  end

  // A head leaves only when every output selecting it has credit (all-or-nothing multicast).
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (sel[o] == SEL_W'(i) && credit[o] == '0) blocked[i] = 1'b1;
      end
    end
    pop = ~empty & ~blocked & {N_IN{state != SWAP}};
  end

  always_comb begin
    fire    = '0;
    crd_ovf = '0;
    for (int o = 0; o < N_OUT; o++) begin
      route[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (sel[o] == SEL_W'(i) && pop[i]) begin
          fire[o]  = 1'b1;
          route[o] = head[i];
        end
      end
      crd_ovf[o] = c_in[o] && !fire[o] && (credit[o] == CRD_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < N_OUT; o++) begin
        d_out_q[o] <= '0;
        credit[o]  <= CRD_MAX;
      end
      c_out_q <= '0;
      err     <= 1'b0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        d_out_q[o] <= fire[o] ? {route[o], 1'b1} : '0;
        if (fire[o] && !c_in[o])
          credit[o] <= credit[o] - CRD_ONE;
        else if (!fire[o] && c_in[o] && credit[o] != CRD_MAX)
          credit[o] <= credit[o] + CRD_ONE;
      end
      c_out_q <= pop;
      if (|(overflow & full) || |crd_ovf) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      ctx_active <= '0;
      ctx_busy   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ctx_sel != ctx_active) begin
            state    <= DRAIN;
            ctx_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (&empty && !(|out_valid)) state <= SWAP;
        end
        SWAP: begin
          ctx_active <= ctx_sel;
          ctx_busy   <= 1'b0;
          state      <= RUN;
        end
        default: begin
          state    <= RUN;
          ctx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWITCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (|(~empty & blocked) && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_ctx_buf.sv
// Directed bench for switch_ctx_buf: routing, multicast, credits, overflow, context swap, reset.
module tb_switch_ctx_buf;

  localparam int DATA_W = 64;
  localparam int CTX_W  = 1;

  logic clk, rst;
  logic [DATA_W:0] d_in_NW, d_in_N, d_in_E, d_in_W, d_in_S;
  logic c_out_NW, c_out_N, c_out_E, c_out_W, c_out_S;
  logic [DATA_W:0] d_out_NW, d_out_N, d_out_NE, d_out_E, d_out_SE, d_out_S, d_out_SW, d_out_W;
  logic c_in_NW, c_in_N, c_in_NE, c_in_E, c_in_SE, c_in_S, c_in_SW, c_in_W;
  logic conf_en;
  logic [CTX_W-1:0] conf_ctx, ctx_sel, ctx_active;
  logic ctx_busy, err;
`ifdef SWITCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  switch_ctx_buf #(.DATA_W(DATA_W), .N_CTX(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .d_in_NW(d_in_NW), .d_in_N(d_in_N), .d_in_E(d_in_E), .d_in_W(d_in_W), .d_in_S(d_in_S),
    .c_out_NW(c_out_NW), .c_out_N(c_out_N), .c_out_E(c_out_E), .c_out_W(c_out_W), .c_out_S(c_out_S),
    .d_out_NW(d_out_NW), .d_out_N(d_out_N), .d_out_NE(d_out_NE), .d_out_E(d_out_E),
    .d_out_SE(d_out_SE), .d_out_S(d_out_S), .d_out_SW(d_out_SW), .d_out_W(d_out_W),
    .c_in_NW(c_in_NW), .c_in_N(c_in_N), .c_in_NE(c_in_NE), .c_in_E(c_in_E),
    .c_in_SE(c_in_SE), .c_in_S(c_in_S), .c_in_SW(c_in_SW), .c_in_W(c_in_W),
    .conf_en(conf_en), .conf_ctx(conf_ctx), .ctx_sel(ctx_sel),
    .ctx_active(ctx_active), .ctx_busy(ctx_busy),
`ifdef SWITCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W:0] tok(input logic [DATA_W-1:0] p);
    return {p, 1'b1};
  endfunction

  task automatic cfg(input logic [CTX_W-1:0] c, input logic [23:0] word);
    conf_en  = 1'b1;
    conf_ctx = c;
    d_in_N   = {{(DATA_W-24){1'b0}}, word, 1'b0};
    tick();
    conf_en  = 1'b0;
    d_in_N   = '0;
  endtask

  initial begin
    rst = 1'b0;
    d_in_NW = '0; d_in_N = '0; d_in_E = '0; d_in_W = '0; d_in_S = '0;
    c_in_NW = 0; c_in_N = 0; c_in_NE = 0; c_in_E = 0;
    c_in_SE = 0; c_in_S = 0; c_in_SW = 0; c_in_W = 0;
    conf_en = 0; conf_ctx = '0; ctx_sel = '0;
    tick(); tick();

    // reset state
    chk("rst_d_out_N",  d_out_N,  '0);
    chk("rst_d_out_E",  d_out_E,  '0);
    chk("rst_d_out_W",  d_out_W,  '0);
    chk("rst_d_out_S",  d_out_S,  '0);
    chk("rst_d_out_NW", d_out_NW, '0);
    chk("rst_d_out_NE", d_out_NE, '0);
    chk("rst_d_out_SW", d_out_SW, '0);
    chk("rst_d_out_SE", d_out_SE, '0);
    chk("rst_c_out", {c_out_NW, c_out_N, c_out_E, c_out_W, c_out_S}, '0);
    chk("rst_err", err, 0);
    chk("rst_ctx_active", ctx_active, 0);
    chk("rst_ctx_busy", ctx_busy, 0);
`ifdef SWITCH_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, '0);
`endif
    rst = 1'b1;
    tick();

    // 1: E -> E, three back-to-back tokens, downstream returns a credit per token
    cfg(0, 24'o77777717);
    d_in_E = tok(64'hA1); tick();
    chk("t1_latency", d_out_E, '0);
    d_in_E = tok(64'hB2); tick();
    chk("t1_tokA", d_out_E, tok(64'hA1));
    chk("t1_cA", c_out_E, 1);
    d_in_E = tok(64'hC3); c_in_E = 1; tick();
    chk("t1_tokB", d_out_E, tok(64'hB2));
    chk("t1_cB", c_out_E, 1);
    d_in_E = '0; tick();
    chk("t1_tokC", d_out_E, tok(64'hC3));
    chk("t1_cC", c_out_E, 1);
    tick();
    c_in_E = 0;
    chk("t1_idle", d_out_E, '0);
    chk("t1_c_idle", c_out_E, 0);

    // 2: N -> N and E multicast, E credits exhausted
    cfg(0, 24'o77777700);
    d_in_N = tok(64'h11); tick();
    chk("t2_latency", d_out_N, '0);
    d_in_N = tok(64'h22); tick();
    chk("t2_p1_N", d_out_N, tok(64'h11));
    chk("t2_p1_E", d_out_E, tok(64'h11));
    chk("t2_p1_c", c_out_N, 1);
    d_in_N = tok(64'h33); c_in_N = 1; tick();
    chk("t2_p2_N", d_out_N, tok(64'h22));
    chk("t2_p2_E", d_out_E, tok(64'h22));
    d_in_N = '0; tick();
    chk("t2_held_N", d_out_N, '0);
    chk("t2_held_E", d_out_E, '0);
    chk("t2_held_c", c_out_N, 0);
    c_in_N = 0; tick();
    chk("t2_held2_N", d_out_N, '0);
    c_in_E = 1; tick();
    c_in_E = 0;
    chk("t2_ret_E", d_out_E, '0);
    tick();
    chk("t2_p3_N", d_out_N, tok(64'h33));
    chk("t2_p3_E", d_out_E, tok(64'h33));
    chk("t2_p3_c", c_out_N, 1);
    c_in_N = 1; c_in_E = 1; tick();
    c_in_N = 0; tick();
    c_in_E = 0;
    chk("t2_err", err, 0);

    // 4: context change with a token pending
    cfg(1, 24'o77777711);
    d_in_N = tok(64'h44); ctx_sel = 1; tick();
    d_in_N = '0;
    chk("t4_busy_drain", ctx_busy, 1);
    chk("t4_active_old", ctx_active, 0);
    tick();
    chk("t4_old_ctx_N", d_out_N, tok(64'h44));
    chk("t4_old_ctx_E", d_out_E, tok(64'h44));
    c_in_N = 1; c_in_E = 1; tick();
    c_in_N = 0; c_in_E = 0;
    chk("t4_busy_wait", ctx_busy, 1);
    chk("t4_idle_N", d_out_N, '0);
    tick();
    chk("t4_busy_swap", ctx_busy, 1);
    chk("t4_active_swap", ctx_active, 0);
    tick();
    chk("t4_busy_done", ctx_busy, 0);
    chk("t4_active_new", ctx_active, 1);
    d_in_E = tok(64'h55); tick();
    d_in_E = '0; tick();
    chk("t4_new_N", d_out_N, tok(64'h55));
    chk("t4_new_E", d_out_E, tok(64'h55));
    chk("t4_new_c", c_out_E, 1);
    c_in_N = 1; c_in_E = 1; tick();
    c_in_N = 0; c_in_E = 0;
    chk("t4_idle2", d_out_N, '0);

    // 3: E <- W, credits run dry, FIFO overflows
    cfg(1, 24'o77777727);
    d_in_W = tok(64'h61); tick();
    d_in_W = tok(64'h62); tick();
    chk("t3_w1", d_out_E, tok(64'h61));
    chk("t3_w1_c", c_out_W, 1);
    d_in_W = tok(64'h63); tick();
    chk("t3_w2", d_out_E, tok(64'h62));
    d_in_W = tok(64'h64); tick();
    chk("t3_blocked", d_out_E, '0);
    chk("t3_err_pre", err, 0);
    d_in_W = tok(64'h65); tick();
    chk("t3_err_drop", err, 1);
    d_in_W = '0; c_in_E = 1; tick();
    chk("t3_err_sticky", err, 1);
    chk("t3_ret", d_out_E, '0);
    tick();
    chk("t3_w3", d_out_E, tok(64'h63));
    tick();
    chk("t3_w4", d_out_E, tok(64'h64));
    tick();
    c_in_E = 0;
    chk("t3_w5_lost", d_out_E, '0);
    chk("t3_err_sticky2", err, 1);

    // 6: reset mid-stream
    d_in_W = tok(64'h71); tick();
    d_in_W = '0; tick();
    chk("t6_pre", d_out_E, tok(64'h71));
    rst = 1'b0; ctx_sel = 0; #1;
    chk("t6_async_d", d_out_E, '0);
    chk("t6_async_c", c_out_W, 0);
    chk("t6_async_err", err, 0);
    chk("t6_async_ctx", ctx_active, 0);
    tick();
    rst = 1'b1;
    d_in_E = tok(64'h72); tick();
    d_in_E = '0; tick();
    chk("t6_unused_E", d_out_E, '0);
    chk("t6_unused_N", d_out_N, '0);
    chk("t6_discard_c", c_out_E, 1);
    chk("t6_busy", ctx_busy, 0);

    // 5: credit return at full credit
    cfg(0, 24'o77773777);
    chk("t5_err_pre", err, 0);
    c_in_S = 1; tick();
    c_in_S = 0;
    chk("t5_err_ovf", err, 1);
    d_in_S = tok(64'h81); tick();
    d_in_S = tok(64'h82); tick();
    chk("t5_s1", d_out_S, tok(64'h81));
    d_in_S = tok(64'h83); tick();
    chk("t5_s2", d_out_S, tok(64'h82));
    d_in_S = '0; tick();
    chk("t5_sat_blocked", d_out_S, '0);
    tick();
    chk("t5_sat_blocked2", d_out_S, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
